// File: rtl/pipelined_decoder.sv
// pipelined_decoder: registered N-to-2^N one-hot decoder with valid pipe, accumulate mode and saturating count.
module pipelined_decoder #(
  parameter int ADDR_W = 2,
  parameter int PIPE_STAGES = 1,
  parameter bit MASK_ZERO = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   en,
  input  logic [ADDR_W-1:0]      a,
  input  logic                   mode,
  input  logic                   clr,
  output logic [(1<<ADDR_W)-1:0] out,
  output logic                   out_valid,
  output logic [CNT_W-1:0]       dec_count
);
  localparam int N = 1 << ADDR_W;
  logic acc, v, inc;
  logic [N-1:0] dec, oh, out_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  assign acc = in_valid & en;
  // dec is forced to zero whenever nothing is accepted, so an unknown a never leaks
  assign dec = (!acc || (MASK_ZERO && a == '0)) ? '0 : {{(N-1){1'b0}}, 1'b1} << a;
  generate
    if (PIPE_STAGES == 2) begin : g_p2
      logic v1;
      logic [N-1:0] oh1;
      always_ff @(posedge clk) begin
        if (rst) begin
          v1 <= 1'b0;
          oh1 <= '0;
        end else begin
          v1 <= acc;
          oh1 <= dec;
        end
      end
      assign v = v1;
      assign oh = oh1;
    end else begin : g_p1
      assign v = acc;
      assign oh = dec;
    end
  endgenerate
  assign inc = v & (|oh);
  always_comb begin
    out_nxt = mode ? (clr ? oh : out | oh) : oh;
    cnt_nxt = clr ? CNT_W'(inc) : (inc && !(&dec_count)) ? dec_count + 1'b1 : dec_count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      out_valid <= 1'b0;
      dec_count <= '0;
    end else begin
      out <= out_nxt;
      out_valid <= v;
      dec_count <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_pipelined_decoder.sv
// tb_pipelined_decoder: table-driven checks on the default build plus directed
// sequences on masked, two-stage and narrow-counter builds.
module tb_pipelined_decoder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, en = 1'b0, mode = 1'b0, clr = 1'b0;
  logic [2:0] a = '0;
  logic [3:0] o1, om;
  logic [7:0] op;
  logic [3:0] oc;
  logic v1, vm, vp, vc;
  logic [15:0] c1, cm, cp;
  logic [3:0] cc;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  pipelined_decoder u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .en(en), .a(a[1:0]),
    .mode(mode), .clr(clr), .out(o1), .out_valid(v1), .dec_count(c1));
  pipelined_decoder #(.MASK_ZERO(1'b1)) um (.clk(clk), .rst(rst), .in_valid(in_valid), .en(en),
    .a(a[1:0]), .mode(mode), .clr(clr), .out(om), .out_valid(vm), .dec_count(cm));
  pipelined_decoder #(.ADDR_W(3), .PIPE_STAGES(2)) up (.clk(clk), .rst(rst), .in_valid(in_valid),
    .en(en), .a(a), .mode(mode), .clr(clr), .out(op), .out_valid(vp), .dec_count(cp));
  pipelined_decoder #(.CNT_W(4)) uc (.clk(clk), .rst(rst), .in_valid(in_valid), .en(en),
    .a(a[1:0]), .mode(mode), .clr(clr), .out(oc), .out_valid(vc), .dec_count(cc));

  typedef struct {
    logic r, iv, e, m, c;
    logic [2:0] a;
    logic [3:0] eo;
    logic eov;
    logic [15:0] ec;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic e, input logic m,
                      input logic c, input logic [2:0] aa);
    @(negedge clk);
    rst = r; in_valid = iv; en = e; mode = m; clr = c; a = aa;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                r  iv e  m  c  a     out   ov    cnt
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0, 4'h0, 1'b0, 16'd0});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,3'd0, 4'h1, 1'b1, 16'd1});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,3'd1, 4'h2, 1'b1, 16'd2});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,3'd2, 4'h4, 1'b1, 16'd3});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,3'd3, 4'h8, 1'b1, 16'd4});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,3'd0, 4'h0, 1'b0, 16'd4});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,3'd2, 4'h0, 1'b0, 16'd4});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,3'd2, 4'h0, 1'b0, 16'd4});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,3'd2, 4'h0, 1'b0, 16'd4});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,3'd3, 4'h8, 1'b1, 16'd5});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0, 4'h0, 1'b0, 16'd5});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1,3'd0, 4'h0, 1'b0, 16'd0});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,3'd1, 4'h2, 1'b1, 16'd1});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,3'd3, 4'hA, 1'b1, 16'd2});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,3'd0, 4'hA, 1'b0, 16'd2});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,3'd0, 4'hA, 1'b0, 16'd2});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b1,3'd0, 4'h1, 1'b1, 16'd1});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0, 4'h0, 1'b0, 16'd1});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,3'd2, 4'h4, 1'b1, 16'd2});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,3'd1, 4'h6, 1'b1, 16'd3});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1,3'd0, 4'h0, 1'b0, 16'd0});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b1,3'd3, 4'h8, 1'b1, 16'd1});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b1,1'b1,3'd2, 4'h0, 1'b0, 16'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].iv, tbl[i].e, tbl[i].m, tbl[i].c, tbl[i].a);
      chk($sformatf("v%0d out", i), 32'(o1), 32'(tbl[i].eo));
      chk($sformatf("v%0d out_valid", i), 32'(v1), 32'(tbl[i].eov));
      chk($sformatf("v%0d dec_count", i), 32'(c1), 32'(tbl[i].ec));
    end

    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'bxxx);
    chk("x_a out", 32'(o1), 32'h0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("mask a0 out", 32'(om), 32'h0);
    chk("mask a0 valid", 32'(vm), 32'h1);
    chk("mask a0 cnt", 32'(cm), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    chk("mask a2 out", 32'(om), 32'h4);
    chk("mask a2 valid", 32'(vm), 32'h1);
    chk("mask a2 cnt", 32'(cm), 32'd1);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
    chk("p2 lat1 valid", 32'(vp), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
    chk("p2 out5", 32'(op), 32'h20);
    chk("p2 valid5", 32'(vp), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("p2 out7", 32'(op), 32'h80);
    chk("p2 valid7", 32'(vp), 32'h1);
    chk("p2 cnt", 32'(cp), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("p2 drain valid", 32'(vp), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
    chk("p2b out5", 32'(op), 32'h20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("p2 rst out", 32'(op), 32'h0);
    chk("p2 rst valid", 32'(vp), 32'h0);
    chk("p2 rst cnt", 32'(cp), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("p2 dropped out", 32'(op), 32'h0);
    chk("p2 dropped valid", 32'(vp), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("p2 dropped valid2", 32'(vp), 32'h0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
      if (i == 14 || i >= 15) chk($sformatf("sat cnt %0d", i), 32'(cc), (i >= 15) ? 32'd15 : 32'd14);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
    chk("sat clr+inc", 32'(cc), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_decoder.md
Name: pipelined_decoder

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable, a valid pipeline and an accumulate mode. It is the successor to the combinational 2-to-4 decoder. Typical uses are register-file write-enable generation and interrupt/line-select bitmaps in the MIPS datapath. An optional zero-index mask reproduces the $zero register convention (index 0 never asserts a line).

Parameters:
ADDR_W, 2, width of select input; output width is 2^ADDR_W.
PIPE_STAGES, 1, decode latency in cycles; legal values 1 or 2.
MASK_ZERO, 0, when 1 index 0 decodes to all-zero output.
CNT_W, 16, width of saturating decode counter.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  select input valid this cycle.
en  in  1  decode enable; accept = in_valid & en.
a  in  ADDR_W  select index.
mode  in  1  0 = pulse, 1 = accumulate; sampled in the output-stage update cycle.
clr  in  1  clears accumulated output and counter (synchronous).
out  out  2^ADDR_W  decoded one-hot (pulse) or OR-accumulated bitmap.
out_valid  out  1  high for one cycle per accepted decode, PIPE_STAGES cycles after accept.
dec_count  out  CNT_W  number of accepted decodes that produced a non-zero one-hot.

Behaviour:
- Reset (rst=1 at edge): all pipeline valid bits, out, out_valid and dec_count go to 0. rst overrides clr, in_valid and mode. In-flight decodes are discarded; nothing emerges after reset deasserts.
- Accept: a sample is taken on a rising edge with in_valid=1 and en=1. If in_valid=0 or en=0, a bubble enters the pipe. No backpressure; one accept per cycle sustained.
- Decode: onehot = 1 << a, width 2^ADDR_W. If MASK_ZERO=1 and a=0, onehot = 0, but out_valid still asserts.
- Latency:
  - PIPE_STAGES=1: a and valid feed the output register directly; out_valid rises the cycle after accept.
  - PIPE_STAGES=2: one intermediate register holds {valid, onehot}; out_valid rises two cycles after accept.
  - Back-to-back accepts produce back-to-back out_valid pulses in order.
- Output stage update, each edge, with v = valid arriving at output stage and oh = its onehot:
  - mode=0 (pulse): out <= v ? oh : 0. clr is irrelevant to out in pulse mode.
  - mode=1 (accumulate):
    - clr=1 and v=1: out <= oh (clear then set).
    - clr=1 and v=0: out <= 0.
    - clr=0: out <= out | (v ? oh : 0).
  - Switching mode 1->0: the next edge behaves as pulse, so out drops to 0 or oh.
  - Switching mode 0->1: accumulation starts from the current out value.
  - out_valid <= v in both modes.
- Counter:
  - Increments when v=1 and oh != 0. Saturates at 2^CNT_W-1; no wrap.
  - clr=1 and increment in the same cycle: dec_count <= 1.
  - clr=1 alone: dec_count <= 0. clr acts on the counter in both modes.
- Input a is don't-care when not accepted; X on a with accept=0 must not propagate.
- No combinational path from inputs to outputs.

Test Plan:
1. ADDR_W=2, PIPE_STAGES=1, mode=0: accept a=0,1,2,3 on consecutive cycles.
   -> out = 1,2,4,8 on the following four cycles, out_valid high for 4 cycles, then out=0. dec_count=4.
2. en=0 with in_valid=1, a=2 for 3 cycles, then en=1 a=3.
   -> out=0 and out_valid=0 for the disabled cycles; a single pulse out=8 one cycle after the enabled accept.
3. mode=1: accept a=1 then a=3, idle 2 cycles, then clr with a simultaneous accept of a=0.
   -> out = 2, then 10, held at 10, then 1 after the clr cycle. dec_count = 2 then 1.
4. MASK_ZERO=1: accept a=0 then a=2.
   -> out_valid pulses twice; out = 0 then 4. dec_count=1.
5. PIPE_STAGES=2, ADDR_W=3: accept a=5, a=7 back-to-back; assert rst one cycle after the second accept.
   -> out=32 with out_valid=1 two cycles after the first accept. The a=7 decode is dropped and out=0 after the reset cycle, with all outputs 0.
6. CNT_W=4: 17 accepts with a=1, no clr.
   -> dec_count saturates at 15 and stays at 15. One further accept together with clr -> dec_count=1.
